// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register-file scoreboard.
// The core drives it as master; the register file is the slave.
interface regfile_scoreboard_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2
);
    // decode side: read addresses and issued destination
    logic [NUM_READ*ADDRESS_WIDTH-1:0] ad_r;
    logic [NUM_READ*DATA_WIDTH-1:0]    rd;
    logic [NUM_READ-1:0]               rd_busy;
    logic                              issue_en;
    logic [ADDRESS_WIDTH-1:0]          issue_ad;
    // writeback side
    logic                              we3;
    logic [ADDRESS_WIDTH-1:0]          ad3;
    logic [DATA_WIDTH-1:0]             wd3;
    // observation
    logic [DATA_WIDTH-1:0]             a0;
    logic [ADDRESS_WIDTH-1:0]          pending_count;

    modport master (
        output ad_r, issue_en, issue_ad, we3, ad3, wd3,
        input  rd, rd_busy, a0, pending_count
    );

    modport slave (
        input  ad_r, issue_en, issue_ad, we3, ad3, wd3,
        output rd, rd_busy, a0, pending_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with hardwired-zero x0, optional writeback
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_scoreboard #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter bit BYPASS        = 1'b1,
    parameter int DEBUG_REG     = 10
) (
    input logic                clk,
    input logic                rst,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = ADDRESS_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_next;
    logic [ADDRESS_WIDTH-1:0] count_next;
    logic [ADDRESS_WIDTH-1:0] count_q;

    logic [ADDRESS_WIDTH-1:0]       read_addr [NUM_READ];
    logic [NUM_READ*DATA_WIDTH-1:0] rd_int;
    logic [NUM_READ-1:0]            rd_busy_int;

    logic write_hit;
    logic issue_hit;

    assign write_hit = bus.we3 && (bus.ad3 != '0);
    assign issue_hit = bus.issue_en && (bus.issue_ad != '0);

    for (genvar g = 0; g < NUM_READ; g++) begin : g_addr
        assign read_addr[g] = bus.ad_r[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end

    // Data storage: writeback updates one register; x0 is never written.
    // NOTE: the whole array is cleared on reset because the architecture
    // promises every register reads 0 immediately after rst, not just x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            regs[bus.ad3] <= bus.wd3;
        end
    end

    // Next scoreboard state: a write retires its producer, then an issue
    // to the same address marks it busy again (new producer wins).
    always_comb begin
        // NOTE: default first so no path leaves busy_next unassigned (latch).
        busy_next = busy;
        if (write_hit) begin
            busy_next[bus.ad3] = 1'b0;
        end
        if (issue_hit) begin
            busy_next[bus.issue_ad] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Population count of the next scoreboard, registered alongside it.
    always_comb begin
        count_next = '0;
        for (int i = 1; i < DEPTH; i++) begin
            count_next = count_next + ADDRESS_WIDTH'(busy_next[i]);
        end
    end

    // Scoreboard and pending counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            count_q <= '0;
        end else begin
            busy    <= busy_next;
            count_q <= count_next;
        end
    end

    // Combinational read ports with x0 masking and optional bypass.
    always_comb begin
        rd_int      = '0;
        rd_busy_int = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (read_addr[i] == '0) begin
                rd_int[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy_int[i]                     = 1'b0;
            end else if (BYPASS && write_hit && (bus.ad3 == read_addr[i])) begin
                rd_int[i*DATA_WIDTH +: DATA_WIDTH] = bus.wd3;
                rd_busy_int[i]                     = 1'b0;
            end else begin
                rd_int[i*DATA_WIDTH +: DATA_WIDTH] = regs[read_addr[i]];
                rd_busy_int[i]                     = busy[read_addr[i]];
            end
        end
    end

    assign bus.rd            = rd_int;
    assign bus.rd_busy       = rd_busy_int;
    // Debug view is architectural state only; x0 stays 0 so DEBUG_REG=0 is constant 0.
    assign bus.a0            = regs[DBG_IDX];
    assign bus.pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: one bypassing and one non-bypassing 3-port register
// file driven by identical stimulus and compared against an array model.
module tb_regfile_scoreboard;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra [NR];
    logic          issue_en;
    logic [AW-1:0] issue_ad;
    logic          we3;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus_b ();
    regfile_scoreboard_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus_n ();

    assign bus_b.ad_r     = {ra[2], ra[1], ra[0]};
    assign bus_b.issue_en = issue_en;
    assign bus_b.issue_ad = issue_ad;
    assign bus_b.we3      = we3;
    assign bus_b.ad3      = ad3;
    assign bus_b.wd3      = wd3;
    assign bus_n.ad_r     = {ra[2], ra[1], ra[0]};
    assign bus_n.issue_en = issue_en;
    assign bus_n.issue_ad = issue_ad;
    assign bus_n.we3      = we3;
    assign bus_n.ad3      = ad3;
    assign bus_n.wd3      = wd3;

    regfile_scoreboard #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(1'b1), .DEBUG_REG(10)
    ) dut_byp (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    regfile_scoreboard #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(1'b0), .DEBUG_REG(10)
    ) dut_nob (
        .clk(clk), .rst(rst), .bus(bus_n)
    );

    // reference model: architectural registers and busy flags
    logic [DW-1:0] m_reg  [32];
    bit            m_busy [32];
    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we3 && ad3 == a) return wd3;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we3 && ad3 == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string ctx);
        for (int p = 0; p < NR; p++) begin
            check($sformatf("%s byp rd%0d", ctx, p), bus_b.rd[p*DW +: DW], exp_rd(ra[p], 1'b1));
            check($sformatf("%s byp busy%0d", ctx, p), DW'(bus_b.rd_busy[p]), DW'(exp_busy(ra[p], 1'b1)));
            check($sformatf("%s nob rd%0d", ctx, p), bus_n.rd[p*DW +: DW], exp_rd(ra[p], 1'b0));
            check($sformatf("%s nob busy%0d", ctx, p), DW'(bus_n.rd_busy[p]), DW'(exp_busy(ra[p], 1'b0)));
        end
        check({ctx, " byp a0"}, bus_b.a0, m_reg[10]);
        check({ctx, " nob a0"}, bus_n.a0, m_reg[10]);
        check({ctx, " byp count"}, DW'(bus_b.pending_count), DW'(m_count()));
        check({ctx, " nob count"}, DW'(bus_n.pending_count), DW'(m_count()));
    endtask

    // One cycle: drive at negedge, check combinational/registered view, take the edge.
    task automatic step(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input bit ie, input logic [AW-1:0] ia,
                        input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input string ctx);
        @(negedge clk);
        ra[0] = r0; ra[1] = r1; ra[2] = r2;
        issue_en = ie; issue_ad = ia; we3 = we; ad3 = wa; wd3 = wd;
        #1;
        check_all(ctx);
        @(posedge clk);
        if (we && wa != 0) begin
            m_reg[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (ie && ia != 0) m_busy[ia] = 1'b1;
    endtask

    // Idle cycle setup: reads only, outputs settle for explicit checks.
    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        ra[0] = r0; ra[1] = r1; ra[2] = r2;
        issue_en = 1'b0; issue_ad = '0; we3 = 1'b0; ad3 = '0; wd3 = '0;
        #1;
    endtask

    initial begin
        logic [AW-1:0] r0, r1, r2, ia, wa;
        bit            ie, we;

        // reset at time zero
        rst = 1'b1;
        ra[0] = 5'd1; ra[1] = 5'd10; ra[2] = 5'd31;
        issue_en = 1'b0; issue_ad = '0; we3 = 1'b0; ad3 = '0; wd3 = '0;
        model_reset();
        #2;
        check_all("reset0");
        @(negedge clk);
        rst = 1'b0;

        // fill x1..x31 with i*3, then mark x5 busy
        for (int i = 1; i < 32; i++) begin
            step(5'd1, AW'(i), 5'd0, 1'b0, '0, 1'b1, AW'(i), DW'(i * 3), "fill");
        end
        step(5'd5, 5'd3, 5'd31, 1'b1, 5'd5, 1'b0, '0, '0, "issue5");
        idle(5'd5, 5'd3, 5'd31);
        check("pre-reset x5 busy", DW'(bus_b.rd_busy[0]), 32'd1);
        check("pre-reset x31", bus_b.rd[2*DW +: DW], 32'd93);

        // asynchronous reset between edges
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset mid");
        check("reset mid count", DW'(bus_b.pending_count), 32'd0);
        #1;
        rst = 1'b0;

        // x0 ignores writes and issues
        step(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, "x0 write");
        idle(5'd0, 5'd0, 5'd0);
        check("x0 rd", bus_b.rd[0 +: DW], 32'd0);
        check("x0 busy", DW'(bus_b.rd_busy[0]), 32'd0);
        check("x0 count", DW'(bus_b.pending_count), 32'd0);

        // scoreboard: issue x7, issue x9, write x7
        step(5'd7, 5'd9, 5'd0, 1'b1, 5'd7, 1'b0, '0, '0, "sb issue7");
        step(5'd7, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, '0, '0, "sb issue9");
        step(5'd7, 5'd9, 5'd0, 1'b0, '0, 1'b1, 5'd7, 32'h1234, "sb write7");
        idle(5'd7, 5'd9, 5'd0);
        check("sb x7 data", bus_b.rd[0 +: DW], 32'h1234);
        check("sb x7 busy", DW'(bus_b.rd_busy[0]), 32'd0);
        check("sb x9 busy", DW'(bus_b.rd_busy[1]), 32'd1);
        check("sb count", DW'(bus_b.pending_count), 32'd1);

        // bypass versus no bypass on a busy register
        step(5'd12, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0, '0, '0, "issue12");
        @(negedge clk);
        ra[0] = 5'd12; ra[1] = 5'd0; ra[2] = 5'd0;
        issue_en = 1'b0; issue_ad = '0; we3 = 1'b1; ad3 = 5'd12; wd3 = 32'hCAFEF00D;
        #1;
        check("bypass rd0", bus_b.rd[0 +: DW], 32'hCAFEF00D);
        check("bypass busy0", DW'(bus_b.rd_busy[0]), 32'd0);
        check("nobypass rd0", bus_n.rd[0 +: DW], 32'd0);
        check("nobypass busy0", DW'(bus_n.rd_busy[0]), 32'd1);
        @(posedge clk);
        m_reg[12]  = 32'hCAFEF00D;
        m_busy[12] = 1'b0;

        // issue/write collision keeps the register busy
        step(5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, '0, '0, "issue3");
        step(5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h55, "collide3");
        idle(5'd3, 5'd0, 5'd0);
        check("collide x3 data", bus_b.rd[0 +: DW], 32'h55);
        check("collide x3 busy", DW'(bus_b.rd_busy[0]), 32'd1);
        check("collide count", DW'(bus_b.pending_count), 32'd2);

        // debug register updates only after the edge
        step(5'd10, 5'd0, 5'd0, 1'b0, '0, 1'b1, 5'd10, 32'hA5A5A5A5, "write a0");
        idle(5'd4, 5'd4, 5'd0);
        check("a0 after edge", bus_b.a0, 32'hA5A5A5A5);
        check("a0 nob after edge", bus_n.a0, 32'hA5A5A5A5);

        // three ports on x4, x4, x0
        step(5'd4, 5'd4, 5'd0, 1'b0, '0, 1'b1, 5'd4, 32'h0BAD_F00D, "write4");
        idle(5'd4, 5'd4, 5'd0);
        check("3port p0", bus_b.rd[0 +: DW], 32'h0BAD_F00D);
        check("3port p1", bus_b.rd[DW +: DW], 32'h0BAD_F00D);
        check("3port p2", bus_b.rd[2*DW +: DW], 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r0 = AW'($urandom_range(0, 31));
            r1 = AW'($urandom_range(0, 31));
            r2 = AW'($urandom_range(0, 31));
            ie = bit'($urandom_range(0, 1));
            ia = AW'($urandom_range(0, 31));
            we = bit'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? r0 : AW'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ia = wa;
            step(r0, r1, r2, ie, ia, we, wa, $urandom, "rand");
        end
        idle(5'd1, 5'd10, 5'd31);
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
